data_mem_responder: RTL and testbench

// - Responder end of the processor data-memory port: a wait-stated data RAM with valid/ready handshake.
// - Accepts one load/store request at a time, inserts WAIT_CYCLES of latency, returns read data or write acknowledge.
// - Sits between the CPU load/store path and on-chip RAM and replaces the zero-latency DataMemory model for multi-cycle cores.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/data_mem_responder_if.sv | 27 ++
 rtl/dmem_byte_array.sv | 30 +++
 rtl/data_mem_responder.sv | 130 +++++++++++++
 tb/tb_data_mem_responder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the wait-stated data-memory responder.
// Bounds-check helper is used only when DMEM_BOUNDS_CHECK_EN is defined.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  function automatic int idx_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Word offset from the base, before truncation to the array's index width.
  function automatic logic [WORD_W-1:0] word_offset(input logic [WORD_W-1:0] addr,
                                                    input logic [WORD_W-1:0] base);
    return (addr - base) >> 2;
  endfunction

  function automatic logic addr_fault(input logic [WORD_W-1:0] addr,
                                      input logic [WORD_W-1:0] base,
                                      input int depth);
    return (addr[1:0] != 2'b00) || (addr < base) ||
           (word_offset(addr, base) >= WORD_W'(depth));
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus of the data-memory port. Both channels use valid/ready:
// a transfer happens on a rising edge where valid and ready are both high.
interface data_mem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );

endinterface

// File: rtl/dmem_byte_array.sv
// DEPTH_WORDS x 32 storage with per-byte-lane write enables and a registered
// read port; read and write share one address and happen only when en is high.
module dmem_byte_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [BE_W-1:0]   we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Wait-stated data RAM responder: one request in flight, WAIT_CYCLES of latency.
// Define DMEM_BOUNDS_CHECK_EN to fault misaligned / out-of-range accesses.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output dmem_state_e          dbg_state
);

  localparam int        AW        = idx_width(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  dmem_state_e       state_q, state_d;
  logic [3:0]        cnt_q;
  logic              accept, commit;
  logic              req_err;

  logic              lat_write, lat_err;
  logic [AW-1:0]     lat_idx;
  logic [WORD_W-1:0] lat_wdata;
  logic [BE_W-1:0]   lat_be;

  logic              cur_write, cur_err;
  logic [AW-1:0]     cur_idx;
  logic [WORD_W-1:0] cur_wdata;
  logic [BE_W-1:0]   cur_be;
  logic [BE_W-1:0]   ram_we;
  logic [WORD_W-1:0] ram_rdata;

  assign accept = bus.req_valid && (state_q == IDLE);

`ifdef DMEM_BOUNDS_CHECK_EN
  assign req_err = addr_fault(bus.req_addr, BASE_ADDR, DEPTH_WORDS);
`else
  assign req_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.req_valid) state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt_q == WAIT_LAST) state_d = RESP;
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
    end else begin
      if (state_q == WAIT && state_d == WAIT) cnt_q <= cnt_q + 4'd1;
      else                                    cnt_q <= '0;
      if (accept) begin
        lat_write <= bus.req_write;
        lat_err   <= req_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_idx   <= AW'(word_offset(bus.req_addr, BASE_ADDR));
      lat_wdata <= bus.req_wdata;
      lat_be    <= bus.req_be;
    end
  end

  // With zero wait states the RAM access happens on the accept edge itself,
  // so the live request fields feed the array instead of the latched copies.
  always_comb begin
    if (state_q == IDLE) begin
      cur_write = bus.req_write;
      cur_err   = req_err;
      cur_idx   = AW'(word_offset(bus.req_addr, BASE_ADDR));
      cur_wdata = bus.req_wdata;
      cur_be    = bus.req_be;
    end else begin
      cur_write = lat_write;
      cur_err   = lat_err;
      cur_idx   = lat_idx;
      cur_wdata = lat_wdata;
      cur_be    = lat_be;
    end
  end

  assign commit = (state_d == RESP) && (state_q != RESP);
  assign ram_we = (commit && cur_write && !cur_err) ? cur_be : '0;

  dmem_byte_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .en    (commit),
    .we    (ram_we),
    .addr  (cur_idx),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  // Output logic; the array is only enabled on the commit edge, so ram_rdata
  // stays put for as long as the response is held in RESP.
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_error = (state_q == RESP) && lat_err;
    bus.rsp_rdata = (state_q == RESP && !lat_write && !lat_err) ? ram_rdata : '0;
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against an array-based memory model.
// Build with +define+DMEM_BOUNDS_CHECK_EN to exercise the fault path.
module tb_data_mem_responder
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
);

  localparam int          DEPTH  = 256;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          PERIOD = 10;

  logic        clk = 1'b0;
  logic        reset;
  dmem_state_e dbg_state;

  data_mem_responder_if bus();

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #(PERIOD/2) clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mem_m [DEPTH];
  logic [32:0] exp_q [$];
  time         last_accept;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_idx(input logic [31:0] a);
    return int'(((a - BASE) >> 2) % DEPTH);
  endfunction

  function automatic bit model_err(input logic [31:0] a);
`ifdef DMEM_BOUNDS_CHECK_EN
    return (a[1:0] != 2'b00) || (a < BASE) || (((a - BASE) >> 2) >= DEPTH);
`else
    return (a === 32'hxxxx_xxxx);
`endif
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int idx;
    idx = model_idx(a);
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem_m[idx][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  // Presents a request, waits for acceptance, then scrambles the request
  // fields so that late input changes would corrupt a non-latching design.
  task automatic drive_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input bit track);
    int  guard;
    bit  err;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq("accept_timeout", 32'(guard), 32'(guard < 50 ? guard : 0));
    @(posedge clk);
    last_accept = $time;
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom_range(0, 1));
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_be    = 4'($urandom_range(0, 15));
    if (track) begin
      err = model_err(a);
      if (wr) begin
        exp_q.push_back({err, 32'h0});
        if (!err) model_store(a, d, be);
      end else begin
        exp_q.push_back({err, err ? 32'h0 : mem_m[model_idx(a)]});
      end
    end
  endtask

  task automatic wait_rsp(input string tag, output logic [31:0] exp_rd);
    int          lat;
    logic [32:0] e;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 100);
    check_eq({tag, "_lat"}, 32'(lat), 32'(WAIT_CYCLES + 1));
    check_eq({tag, "_qsize"}, 32'(exp_q.size()), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h0;
    exp_rd = e[31:0];
    check_eq({tag, "_rdata"}, bus.rsp_rdata, e[31:0]);
    check_eq({tag, "_err"}, 32'(bus.rsp_error), 32'(e[32]));
  endtask

  task automatic release_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check_eq({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check_eq({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
    check_eq({tag, "_rsp_error"}, 32'(bus.rsp_error), 32'd0);
    check_eq({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    #(PERIOD * 60000);
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e;
    logic [31:0] a;
    time         prev;
    int          d;

    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive_req(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 1'b1);
      wait_rsp("preload", e);
      release_rsp();
    end

    // Full-word store then load; latency is checked inside wait_rsp.
    drive_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
    wait_rsp("st10", e);
    release_rsp();
    drive_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    wait_rsp("ld10", e);
    check_eq("ld10_literal", bus.rsp_rdata, 32'hDEAD_BEEF);
    release_rsp();

    // Partial-lane store merge.
    drive_req(1'b1, 32'h20, 32'h1122_3344, 4'hF, 1'b1);
    wait_rsp("st20", e);
    release_rsp();
    drive_req(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b1);
    wait_rsp("st20_be", e);
    release_rsp();
    drive_req(1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
    wait_rsp("ld20", e);
    check_eq("be_merge", bus.rsp_rdata, 32'h11BB_33DD);
    release_rsp();

    // Response back-pressure with a competing request on the bus.
    drive_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    wait_rsp("hold", e);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h30;
    bus.req_wdata = 32'h5555_AAAA;
    bus.req_be    = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("hold_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
      check_eq("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_eq("hold_after_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("hold_after_ready", 32'(bus.req_ready), 32'd1);

    // Address one full array past the base.
    drive_req(1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0, 1'b1);
    wait_rsp("wrap", e);
    release_rsp();

    // Reset one cycle after accepting a store.
    drive_req(1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_idle_outputs("midrst");
    if (WAIT_CYCLES == 0) model_store(32'h40, 32'hCAFE_F00D, 4'hF);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive_req(1'b0, 32'h40, 32'h0, 4'h0, 1'b1);
    wait_rsp("ld40", e);
    release_rsp();

    // Back-to-back loads: accept-to-accept spacing.
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      drive_req(1'b0, BASE + 32'(4 * k), 32'h0, 4'h0, 1'b1);
      if (k > 0) check_eq("b2b_gap", 32'(last_accept - prev), 32'((WAIT_CYCLES + 2) * PERIOD));
      prev = last_accept;
      wait_rsp("b2b", e);
      release_rsp();
    end

    for (int t = 0; t < 60; t++) begin
      a = BASE + 32'(4 * $urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0:       a = a + 32'($urandom_range(1, 3));
        1:       a = a + 32'(4 * DEPTH);
        default: ;
      endcase
      drive_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1'b1);
      wait_rsp("rand", e);
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        @(negedge clk);
        check_eq("rand_hold", bus.rsp_rdata, e);
      end
      release_rsp();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
